// File: rtl/rv32im_regfile_mp.sv
// rv32im_regfile_mp
//   Integer register file for the rv32im core with NUM_READ registered read
//   ports, one write port, an optional same-cycle write-through bypass and a
//   post-reset sweep that zeroes x1..x(2^REG_BITS-1).
//
// Ports
//   clk_i      rising-edge clock for all state
//   rst_ni     synchronous active-low reset
//   write_i    write strobe (ignored while busy_o)
//   rd_addr_i  write address; x0 writes are dropped
//   data_i     write data
//   read_i     per-port read enable; a cleared bit holds that port's output
//   rs_addr_i  packed read addresses, port p at [p*REG_BITS +: REG_BITS]
//   rs_o       packed read data, port p at [p*XLEN +: XLEN], 1-cycle latency
//   busy_o     high during reset and the clear sweep
//
// State  | meaning
// -------+-------------------------------------------------------------
// CLEAR  | sweeping zeros into x1..xN, one entry per edge; busy
// RUN    | normal operation (first edge after reset is still busy when
//        | the sweep is skipped)

module rv32im_regfile_mp #(
    parameter int XLEN           = 32,
    parameter int REG_BITS       = 5,
    parameter int NUM_READ       = 2,
    parameter int WRITE_THROUGH  = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         write_i,
    input  logic [REG_BITS-1:0]          rd_addr_i,
    input  logic [XLEN-1:0]              data_i,
    input  logic [NUM_READ-1:0]          read_i,
    input  logic [NUM_READ*REG_BITS-1:0] rs_addr_i,
    output logic [NUM_READ*XLEN-1:0]     rs_o,
    output logic                         busy_o
);

    localparam int                DEPTH = 1 << REG_BITS;
    localparam logic [REG_BITS-1:0] LAST_IDX = REG_BITS'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [REG_BITS-1:0]        clr_cnt_q, clr_cnt_d;
    logic                       busy_q, busy_d;
    logic [NUM_READ*XLEN-1:0]   rs_q, rs_d;

    logic [XLEN-1:0]            mem_q [DEPTH];
    logic                       mem_we;
    logic [REG_BITS-1:0]        mem_waddr;
    logic [XLEN-1:0]            mem_wdata;

    logic [REG_BITS-1:0]        raddr;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        rs_d      = rs_q;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        raddr     = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + REG_BITS'(1);
                rs_d      = '0;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (busy_q) begin
                    // Sweep skipped: the first edge out of reset only drops busy.
                    busy_d = 1'b0;
                end else begin
                    if (write_i && (rd_addr_i != '0)) begin
                        mem_we    = 1'b1;
                        mem_waddr = rd_addr_i;
                        mem_wdata = data_i;
                    end
                    for (int p = 0; p < NUM_READ; p++) begin
                        raddr = rs_addr_i[p*REG_BITS +: REG_BITS];
                        if (read_i[p]) begin
                            if (raddr == '0) begin
                                rs_d[p*XLEN +: XLEN] = '0;
                            end else if ((WRITE_THROUGH != 0) && write_i &&
                                         (rd_addr_i == raddr)) begin
                                rs_d[p*XLEN +: XLEN] = data_i;
                            end else begin
                                rs_d[p*XLEN +: XLEN] = mem_q[raddr];
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= REG_BITS'(1);
            busy_q    <= 1'b1;
            rs_q      <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            rs_q      <= rs_d;
        end
    end

    // Storage has no reset; the reset edge itself must not write it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rs_o   = rs_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_rv32im_regfile_mp.sv
module tb_rv32im_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write;
    logic [4:0]  rd_addr;
    logic [31:0] data;

    // dut_a: defaults (2 ports, write-through); dut_b: 3 ports, no write-through.
    logic [1:0]  read_a;
    logic [9:0]  rs_addr_a;
    logic [63:0] rs_a;
    logic        busy_a;

    logic [2:0]  read_b;
    logic [14:0] rs_addr_b;
    logic [95:0] rs_b;
    logic        busy_b;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    always #5 clk = ~clk;

    // Port 2 of dut_b mirrors port 1 so all three ports see the same checks.
    assign read_b    = {read_a[1], read_a};
    assign rs_addr_b = {rs_addr_a[9:5], rs_addr_a};

    rv32im_regfile_mp u_dut_a (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .write_i   (write),
        .rd_addr_i (rd_addr),
        .data_i    (data),
        .read_i    (read_a),
        .rs_addr_i (rs_addr_a),
        .rs_o      (rs_a),
        .busy_o    (busy_a)
    );

    rv32im_regfile_mp #(
        .NUM_READ      (3),
        .WRITE_THROUGH (0)
    ) u_dut_b (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .write_i   (write),
        .rd_addr_i (rd_addr),
        .data_i    (data),
        .read_i    (read_b),
        .rs_addr_i (rs_addr_b),
        .rs_o      (rs_b),
        .busy_o    (busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ports(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] eb0);
        chk({tag, "_a0"}, rs_a[31:0], e0);
        chk({tag, "_a1"}, rs_a[63:32], e1);
        chk({tag, "_b0"}, rs_b[31:0], eb0);
        chk({tag, "_b1"}, rs_b[63:32], e1);
        chk({tag, "_b2"}, rs_b[95:64], e1);
    endtask

    // Counts edges from now until busy drops on dut_a, bounded at 40.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (!busy_a) break;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        write     = 1'b0;
        rd_addr   = '0;
        data      = '0;
        read_a    = '0;
        rs_addr_a = '0;
        tick();
        tick();
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        chk_ports("rst_rs", 32'h0, 32'h0, 32'h0);

        // Sweep with a write of 0xDEAD to x5 and reads requested the whole time.
        rst_n     = 1'b1;
        write     = 1'b1;
        rd_addr   = 5'd5;
        data      = 32'h0000DEAD;
        read_a    = 2'b11;
        rs_addr_a = {5'd5, 5'd5};
        tick();
        chk("busy_rs_a0", rs_a[31:0], 32'h0);
        count_busy(cnt);
        chk("sweep_edges", 32'(cnt + 1), 32'd31);
        chk("sweep_busy_b", 32'(busy_b), 32'd0);

        // First RUN edge: write x5=0x1234 and read x5 on port 0 only.
        data      = 32'h00001234;
        read_a    = 2'b01;
        rs_addr_a = {5'd6, 5'd5};
        tick();
        chk("x5_wt_a", rs_a[31:0], 32'h00001234);
        chk("x5_old_b", rs_b[31:0], 32'h0);
        write     = 1'b0;
        read_a    = 2'b11;
        rs_addr_a = {5'd6, 5'd5};
        tick();
        chk_ports("x5_x6", 32'h00001234, 32'h0, 32'h00001234);

        // Two/three ports on the same register.
        write   = 1'b1;
        rd_addr = 5'd7;
        data    = 32'hCAFEF00D;
        read_a  = 2'b00;
        tick();
        write     = 1'b0;
        read_a    = 2'b11;
        rs_addr_a = {5'd7, 5'd7};
        tick();
        chk_ports("x7", 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);

        // Same-edge write/read of x3; port 1 disabled and holds.
        write   = 1'b1;
        rd_addr = 5'd3;
        data    = 32'h00000011;
        read_a  = 2'b00;
        tick();
        data      = 32'hA5A5A5A5;
        read_a    = 2'b01;
        rs_addr_a = {5'd3, 5'd3};
        tick();
        chk_ports("x3_same", 32'hA5A5A5A5, 32'hCAFEF00D, 32'h00000011);
        write = 1'b0;
        tick();
        chk_ports("x3_next", 32'hA5A5A5A5, 32'hCAFEF00D, 32'hA5A5A5A5);

        // x0 is hardwired to zero.
        write   = 1'b1;
        rd_addr = 5'd0;
        data    = 32'hFFFFFFFF;
        read_a  = 2'b00;
        tick();
        write     = 1'b0;
        read_a    = 2'b11;
        rs_addr_a = {5'd0, 5'd0};
        tick();
        chk_ports("x0_read", 32'h0, 32'h0, 32'h0);
        write = 1'b1;
        tick();
        chk_ports("x0_same", 32'h0, 32'h0, 32'h0);

        // Port 1 disabled while x9 changes 1 -> 2.
        rd_addr = 5'd9;
        data    = 32'h00000001;
        read_a  = 2'b00;
        tick();
        write     = 1'b0;
        read_a    = 2'b10;
        rs_addr_a = {5'd9, 5'd0};
        tick();
        chk("x9_one", rs_a[63:32], 32'h00000001);
        write  = 1'b1;
        data   = 32'h00000002;
        read_a = 2'b00;
        tick();
        write = 1'b0;
        tick();
        chk("x9_hold_a", rs_a[63:32], 32'h00000001);
        chk("x9_hold_b", rs_b[95:64], 32'h00000001);
        read_a = 2'b10;
        tick();
        chk("x9_load_a", rs_a[63:32], 32'h00000002);
        chk("x9_load_b2", rs_b[95:64], 32'h00000002);

        // Last entry is writable before the final sweep.
        write   = 1'b1;
        rd_addr = 5'd31;
        data    = 32'h55555555;
        read_a  = 2'b00;
        tick();
        write     = 1'b0;
        read_a    = 2'b11;
        rs_addr_a = {5'd7, 5'd31};
        tick();
        chk_ports("x31", 32'h55555555, 32'hCAFEF00D, 32'h55555555);

        // Reset in RUN, then a reset pulse at sweep step 10 restarts the sweep.
        rst_n = 1'b0;
        tick();
        chk("run_rst_busy", 32'(busy_a), 32'd1);
        chk_ports("run_rst_rs", 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("step10_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_busy(cnt);
        chk("resweep_edges", 32'(cnt), 32'd31);
        chk("resweep_busy_b", 32'(busy_b), 32'd0);
        tick();
        chk_ports("after_sweep", 32'h0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
